// File: rtl/sys_feeder_pkg.sv
// Shared definitions for the systolic-array edge feeder.
// Latency: none (types and constant helpers only).
// Backpressure: not applicable.
package sys_feeder_pkg;

  // Feeder control states, 2-bit encoded.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit offset of lane 'lane' inside a packed bus of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sys_feeder_skew_lane.sv
// Skew lane: DEPTH delay stages plus one output stage of {valid,data} for one array row.
// Latency: a word injected on a shift appears on q_* after DEPTH further shifts.
// Backpressure: every stage advances only when shift is high and holds otherwise.
module sys_feeder_skew_lane #(
  parameter int dataWidth = 32,
  parameter int DEPTH     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift,
  input  logic                 d_valid,
  input  logic [dataWidth-1:0] d_data,
  output logic                 q_valid,
  output logic [dataWidth-1:0] q_data
);

  // Stage 0 is the entry; stage DEPTH drives the array edge.
  logic [DEPTH:0][dataWidth:0] stage_q;

  if (DEPTH == 0) begin : g_single
    // Lane 0 has only its output stage.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       stage_q <= '0;
      else if (shift) stage_q <= {d_valid, d_data};
    end
  end else begin : g_chain
    // Whole chain moves one stage towards the output per shift.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       stage_q <= '0;
      else if (shift) stage_q <= {stage_q[DEPTH-1:0], d_valid, d_data};
    end
  end

  assign {q_valid, q_data} = stage_q[DEPTH];

endmodule

// File: rtl/sys_feeder.sv
// sys_feeder: takes one column slice per beat and drives it diagonally skewed onto the array edge.
// Latency: beat accepted at edge t is on lane 0 in cycle t+1 and on lane r after r more shifts.
// Backpressure: in_ready only in STREAM; a cycle without in_valid freezes every skew stage.
module sys_feeder
  import sys_feeder_pkg::*;
#(
  parameter int dataWidth    = 32,
  parameter int featureLen   = 128,
  parameter int SysDimension = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SysDimension*dataWidth-1:0] in_data,
  output logic [SysDimension*dataWidth-1:0] featureRow,
  output logic [SysDimension-1:0]           rowValid,
  output logic                              enable,
  output logic                              busy,
  output logic                              tile_done
);

  localparam int BW = $clog2(featureLen + 1);
  localparam int FW = $clog2(SysDimension + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(featureLen - 1);
  // Only meaningful when there is a skew to drain (SysDimension > 1).
  localparam logic [FW-1:0] LAST_FLUSH = FW'((SysDimension > 1) ? SysDimension - 2 : 0);

  state_t        state;
  logic [BW-1:0] beatCnt;
  logic [FW-1:0] flushCnt;
  logic          accept;
  logic          shift;
  logic          inject_vld;

  assign in_ready   = (state == STREAM);
  assign busy       = (state != IDLE);
  assign accept     = in_valid & in_ready;
  // Drain cycles shift unconditionally so the tail reaches the last row.
  assign shift      = accept | (state == FLUSH);
  // Drain injects zero words marked invalid.
  assign inject_vld = (state == STREAM);

  // Tile sequencing, beat/drain counting and the registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beatCnt   <= '0;
      flushCnt  <= '0;
      enable    <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      enable    <= shift;
      tile_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            state   <= STREAM;
            beatCnt <= '0;
          end
        end
        STREAM: begin
          if (accept) begin
            beatCnt <= beatCnt + 1'b1;
            if (beatCnt == LAST_BEAT) begin
              flushCnt <= '0;
              state    <= (SysDimension == 1) ? DONE : FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flushCnt == LAST_FLUSH) state <= DONE;
          else                        flushCnt <= flushCnt + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < SysDimension; r++) begin : g_lane
    logic [dataWidth-1:0] lane_in;
    assign lane_in = inject_vld ? in_data[lane_lo(r, dataWidth) +: dataWidth] : '0;

    sys_feeder_skew_lane #(
      .dataWidth (dataWidth),
      .DEPTH     (r)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .shift   (shift),
      .d_valid (inject_vld),
      .d_data  (lane_in),
      .q_valid (rowValid[r]),
      .q_data  (featureRow[lane_lo(r, dataWidth) +: dataWidth])
    );
  end

endmodule
